ps2_kbd_fifo: RTL

Parametrised PS/2 keyboard receiver with a scan-code FIFO, frame error detection, receive timeout and interrupt generation. Sits on the internal I/O bus next to the mouse interface and supersedes the single-byte keyboard path: software reads status and scan codes through two word addresses. It tolerates bursts of scan codes while software is busy, and it reports parity, framing and overflow faults instead of silently delivering bad bytes.

---
 rtl/ps2_kbd_fifo_pkg.sv | 28 ++
 rtl/ps2_kbd_fifo_if.sv | 20 ++
 rtl/ps2_kbd_fifo_rx.sv | 126 ++++++++++++
 rtl/ps2_kbd_fifo.sv | 128 ++++++++++++
 4 files changed

// File: rtl/ps2_kbd_fifo_pkg.sv
// Shared definitions for the PS/2 keyboard receiver and its scan-code FIFO.
// Register map, status bit layout, receiver states and parity helper.
package ps2_kbd_fifo_pkg;

    localparam logic ADDR_STATUS = 1'b0;
    localparam logic ADDR_DATA   = 1'b1;

    localparam int ST_RDY    = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVF    = 2;
    localparam int ST_PERR   = 3;
    localparam int ST_FERR   = 4;
    localparam int ST_CNT    = 8;
    localparam int ST_IRQ_EN = 16;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    function automatic logic odd_parity_ok(input logic [7:0] d,
                                           input logic       p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_kbd_fifo_if.sv
// Zero-wait-state I/O bus seen by the keyboard controller.
// The CPU side is the master, the controller is the slave.
interface ps2_kbd_fifo_if;
    logic        stb;
    logic        we;
    logic        addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;

    modport master (
        output stb, we, addr, data_in,
        input  data_out, ack
    );

    modport slave (
        input  stb, we, addr, data_in,
        output data_out, ack
    );
endinterface

// File: rtl/ps2_kbd_fifo_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, frame FSM,
// timeout and parity/stop checks; emits one-cycle result strobes.
module ps2_rx
    import ps2_kbd_fifo_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       keybd_clk,
    input  logic       keybd_data,
    output logic       valid_o,
    output logic [7:0] rx_byte_o,
    output logic       parity_err_o,
    output logic       frame_err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] kclk_q;
    logic [SYNC_STAGES-1:0] kdat_q;
    logic                   kclk_prev_q;
    logic                   fall;
    logic                   din;

    rx_state_e     state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          valid_q, valid_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic          timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kclk_q      <= '1;
            kdat_q      <= '1;
            kclk_prev_q <= 1'b1;
        end else begin
            kclk_q      <= {kclk_q[SYNC_STAGES-2:0], keybd_clk};
            kdat_q      <= {kdat_q[SYNC_STAGES-2:0], keybd_data};
            kclk_prev_q <= kclk_q[SYNC_STAGES-1];
        end
    end

    assign fall    = kclk_prev_q & ~kclk_q[SYNC_STAGES-1];
    assign din     = kdat_q[SYNC_STAGES-1];
    // Any gap between falling edges this long abandons the frame.
    assign timeout = (state_q != RX_IDLE) && !fall && (tmo_q == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RX_IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            valid_q  <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
            valid_q  <= valid_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = RX_IDLE;
        end else if (fall) begin
            unique case (state_q)
                RX_IDLE:   if (!din) state_d = RX_DATA;
                RX_DATA:   if (bitcnt_q == 3'd7) state_d = RX_PARITY;
                RX_PARITY: state_d = RX_STOP;
                RX_STOP:   state_d = RX_IDLE;
                default:   state_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        valid_d  = 1'b0;
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
        if (state_q == RX_IDLE || fall || timeout) tmo_d = '0;
        else                                        tmo_d = tmo_q + 1'b1;
        if (timeout) begin
            ferr_d = 1'b1;
        end else if (fall) begin
            unique case (state_q)
                RX_IDLE:   bitcnt_d = '0;
                RX_DATA: begin
                    shreg_d  = {din, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                end
                RX_PARITY: par_d = din;
                RX_STOP: begin
                    if (!din)                             ferr_d  = 1'b1;
                    else if (!odd_parity_ok(shreg_q, par_q)) perr_d = 1'b1;
                    else                                  valid_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign valid_o      = valid_q;
    assign rx_byte_o    = shreg_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard controller: receiver, scan-code FIFO, sticky error flags,
// status/data register decode and level interrupt.
module ps2_kbd_fifo
    import ps2_kbd_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    ps2_kbd_fifo_if.slave        bus,
    output logic                 irq,
    input  logic                 keybd_clk,
    input  logic                 keybd_data
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_perr;
    logic       rx_ferr;

    ps2_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .keybd_clk   (keybd_clk),
        .keybd_data  (keybd_data),
        .valid_o     (rx_valid),
        .rx_byte_o   (rx_byte),
        .parity_err_o(rx_perr),
        .frame_err_o (rx_ferr)
    );

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  irq_en_q, irq_en_d;

    logic        rdy, full;
    logic        rd, rd_data, pop;
    logic        ctrl_wr, flush;
    logic        push_ok, ovf_set;
    logic [2:0]  w1c;
    logic [31:0] status;
    logic        unused_data_in;

    assign rdy     = (count_q != '0);
    assign full    = (count_q == CW'(DEPTH));
    assign rd      = bus.stb & ~bus.we;
    assign rd_data = rd & (bus.addr == ADDR_DATA);
    assign pop     = rd_data & rdy;
    assign ctrl_wr = bus.stb & bus.we & (bus.addr == ADDR_STATUS);
    assign flush   = bus.stb & bus.we & (bus.addr == ADDR_DATA);
    assign w1c     = ctrl_wr ? bus.data_in[4:2] : 3'b000;

    // A pop or flush in the same cycle frees the slot the push needs.
    assign push_ok = rx_valid & (~full | pop | flush);
    assign ovf_set = rx_valid & full & ~pop & ~flush;

    assign unused_data_in = ^{bus.data_in[31:17], bus.data_in[15:5],
                              bus.data_in[1:0]};

    always_comb begin
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push_ok);
        rd_ptr_d = flush ? wr_ptr_q : rd_ptr_q + DEPTH_LOG2'(pop);
        count_d  = flush ? CW'(push_ok)
                         : count_q + CW'(push_ok) - CW'(pop);
        ovf_d    = (ovf_q  & ~w1c[0]) | ovf_set;
        perr_d   = (perr_q & ~w1c[1]) | rx_perr;
        ferr_d   = (ferr_q & ~w1c[2]) | rx_ferr;
        irq_en_d = ctrl_wr ? bus.data_in[ST_IRQ_EN] : irq_en_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
            irq_en_q <= irq_en_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= rx_byte;
    end

    always_comb begin
        status              = '0;
        status[ST_RDY]      = rdy;
        status[ST_FULL]     = full;
        status[ST_OVF]      = ovf_q;
        status[ST_PERR]     = perr_q;
        status[ST_FERR]     = ferr_q;
        status[ST_CNT +: CW] = count_q;
        status[ST_IRQ_EN]   = irq_en_q;
    end

    always_comb begin
        bus.data_out = '0;
        if (rd && bus.addr == ADDR_STATUS) bus.data_out = status;
        else if (pop)                      bus.data_out = {24'h0, mem_q[rd_ptr_q]};
    end

    assign bus.ack = bus.stb;
    assign irq     = irq_en_q & (rdy | ovf_q | perr_q | ferr_q);

endmodule
